pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the latch chain (latch1..latchN, e.g. latch5raro = bit 4).
//  Drives a per-latch enable and a per-latch bubble (load NOP: instr=0, iset=`ISET_BASE, pc=0).
//  Arbitrates three stall/flush sources: memory busy, branch flush and RO-stage RAW hazard.
//  Bubble is applied by a mux in front of each latch's instr/iset/pc inputs.
// PARAMETERS
//  NUM_LATCH  8   number of pipeline latches; bit k of the vectors = latch k+1
//  HOLD_IDX   4   highest latch bit frozen on a hazard (4 = latch5raro; RO holds its instr)
//  FLUSH_IDX  6   latch bits 0..FLUSH_IDX-1 get a bubble on a flush
// PORTS
//  clk          in   1          clock
//  rst          in   1          asynchronous reset, active-high
//  mem_busy     in   1          memory stage not ready; freeze the whole pipe
//  flush_req    in   1          taken branch/iset switch resolved; kill younger instrs
//  haz_req      in   1          RAW hazard detected in RO stage
//  haz_len      in   2          hazard stall length in cycles (0 treated as 1)
//  stat_clr     in   1          synchronous clear of stall_cycles
//  enable_out   out  NUM_LATCH  per-latch load enable
//  bubble_out   out  NUM_LATCH  per-latch NOP insert (only meaningful with enable=1)
//  stall_out    out  1          any enable bit low this cycle
//  state_out    out  2          00 RUN, 01 HAZ, 10 MEM
//  stall_cycles out  16         saturating count of stalled cycles
// BEHAVIOUR
//  Clock/reset: one clock (clk); reset is asynchronous and active-high (rst).
//  Reset: state=RUN, cnt=0, ret_state=RUN, stall_cycles=0.
//   While rst=1: enable_out=0, bubble_out=0, stall_out=0.
//  Outputs: enable_out/bubble_out/stall_out are combinational from state + current inputs
//   (zero latency); state, cnt and stall_cycles are registered.
//  Priority in every state: mem_busy > flush_req > haz_req.
//  Patterns:
//   FREEZE: enable=0, bubble=0
//   FLUSH:  enable=all 1; bubble bits [FLUSH_IDX-1:0]=1
//   HOLD:   enable bits [HOLD_IDX:0]=0; enable bits above =1; bubble bit HOLD_IDX+1=1
//   PASS:   enable=all 1, bubble=0
//  RUN:
//   mem_busy=1 -> FREEZE; ret_state<=RUN; ->MEM.
//   Else flush_req=1 -> FLUSH; stay RUN; haz_req ignored.
//   Else haz_req=1 -> HOLD; L=max(haz_len,1); cnt<=L-1; ->HAZ if L>1, else stay RUN.
//   Else PASS.
//  HAZ:
//   mem_busy=1 -> FREEZE; ret_state<=HAZ; cnt held; ->MEM.
//   Else flush_req=1 -> FLUSH; cnt<=0; ->RUN (hazard belongs to a killed instruction).
//   Else HOLD; cnt<=cnt-1; ->RUN when cnt==1. haz_req/haz_len ignored in HAZ.
//  MEM:
//   mem_busy=1 -> FREEZE; flush_req and haz_req ignored.
//   mem_busy=0 -> output pattern and transition exactly as in ret_state this cycle.
//   The cycle after a stall ends is evaluated in RUN: haz_req still high = new request.
//  stall_cycles:
//   +1 on every cycle stall_out=1; saturates at 16'hFFFF.
//   stat_clr=1 -> 0 (clear wins over increment).
//  Total HOLD cycles for one hazard = L, excluding cycles frozen in MEM.
//  Width: cnt is 2 bits; no wrap is possible because the load is at most 2.
// TESTING
//  T1 reset: assert rst mid-HAZ (cnt=2) -> enable/bubble=0 at once.
//   After release: state_out=00, stall_cycles=0, enable_out=8'hFF.
//  T2 hazard: haz_req=1, haz_len=3 for 1 cycle in RUN
//   -> 3 cycles enable_out=8'hE0, bubble_out=8'h20; then 8'hFF/8'h00; stall_cycles=3.
//  T3 flush: flush_req=1 in RUN -> enable_out=8'hFF, bubble_out=8'h3F for 1 cycle.
//   flush+haz in the same cycle -> same FLUSH pattern, state stays 00.
//  T4 mem in HAZ: haz_len=3, mem_busy high on 2nd HAZ cycle for 4 cycles
//   -> enable=0 for 4 cycles, then 1 more HOLD cycle; stall_cycles=7.
//  T5 flush aborts hazard: HAZ with cnt=2, flush_req=1 -> bubble_out=8'h3F that cycle.
//   Next cycle state_out=00, enable_out=8'hFF.
//  T6 saturation/clear: preload by holding mem_busy 65540 cycles -> stall_cycles=FFFF.
//   stat_clr=1 with mem_busy=1 -> 0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline control sources and the latch sequencer.
// The master side raises stall/flush requests; the slave side returns latch enables and status.
interface pipe_ctrl_if #(
    parameter int NUM_LATCH = 8
);
    logic                 mem_busy;
    logic                 flush_req;
    logic                 haz_req;
    logic [1:0]           haz_len;
    logic                 stat_clr;
    logic [NUM_LATCH-1:0] enable_out;
    logic [NUM_LATCH-1:0] bubble_out;
    logic                 stall_out;
    logic [1:0]           state_out;
    logic [15:0]          stall_cycles;

    modport master (
        output mem_busy, flush_req, haz_req, haz_len, stat_clr,
        input  enable_out, bubble_out, stall_out, state_out, stall_cycles
    );

    modport slave (
        input  mem_busy, flush_req, haz_req, haz_len, stat_clr,
        output enable_out, bubble_out, stall_out, state_out, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-latch enable/bubble generation with memory-freeze, branch-flush
// and RAW-hazard hold arbitration (mem_busy > flush_req > haz_req), plus a stall counter.
module pipe_ctrl #(
    parameter int NUM_LATCH = 8,
    parameter int HOLD_IDX  = 4,
    parameter int FLUSH_IDX = 6
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_RUN = 2'b00,
        ST_HAZ = 2'b01,
        ST_MEM = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        PAT_FREEZE,
        PAT_FLUSH,
        PAT_HOLD,
        PAT_PASS
    } pattern_t;

    localparam logic [NUM_LATCH-1:0] L_ALL_ONES  = {NUM_LATCH{1'b1}};
    localparam logic [NUM_LATCH-1:0] L_FLUSH_BUB = NUM_LATCH'((1 << FLUSH_IDX) - 1);
    localparam logic [NUM_LATCH-1:0] L_HOLD_EN   = ~NUM_LATCH'((1 << (HOLD_IDX + 1)) - 1);
    localparam logic [NUM_LATCH-1:0] L_HOLD_BUB  = NUM_LATCH'(1 << (HOLD_IDX + 1));

    state_t      r_state;
    state_t      r_ret_state;
    logic [1:0]  r_cnt;
    logic [15:0] r_stall_cycles;

    state_t      w_eff_state;
    pattern_t    w_pat;
    logic        w_stall;
    logic [1:0]  w_haz_len;

    // A released MEM stall behaves exactly like the state it interrupted.
    assign w_eff_state = (r_state == ST_MEM) ? r_ret_state : r_state;
    assign w_haz_len   = (bus.haz_len == 2'd0) ? 2'd1 : bus.haz_len;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        w_pat = PAT_PASS;
        if (bus.mem_busy)
            w_pat = PAT_FREEZE;
        else if (bus.flush_req)
            w_pat = PAT_FLUSH;
        else if (w_eff_state == ST_HAZ || bus.haz_req)
            w_pat = PAT_HOLD;
    end

    assign w_stall = (w_pat == PAT_FREEZE) || (w_pat == PAT_HOLD);

    always_comb begin
        bus.enable_out = '0;
        bus.bubble_out = '0;
        bus.stall_out  = 1'b0;
        if (!rst) begin
            bus.stall_out = w_stall;
            case (w_pat)
                PAT_FREEZE: ;
                PAT_FLUSH: begin
                    bus.enable_out = L_ALL_ONES;
                    bus.bubble_out = L_FLUSH_BUB;
                end
                PAT_HOLD: begin
                    bus.enable_out = L_HOLD_EN;
                    bus.bubble_out = L_HOLD_BUB;
                end
                default: bus.enable_out = L_ALL_ONES;
            endcase
        end
    end

    assign bus.state_out    = r_state;
    assign bus.stall_cycles = r_stall_cycles;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_ret_state    <= ST_RUN;
            r_cnt          <= 2'd0;
            r_stall_cycles <= 16'd0;
        end else begin
            if (bus.stat_clr)
                r_stall_cycles <= 16'd0;
            else if (w_stall && (r_stall_cycles != 16'hFFFF))
                r_stall_cycles <= r_stall_cycles + 16'd1;

            if (bus.mem_busy) begin
                r_state <= ST_MEM;
                if (r_state != ST_MEM)
                    r_ret_state <= r_state;
            end else if (bus.flush_req) begin
                // Any pending hazard belonged to an instruction that is now killed.
                r_state <= ST_RUN;
                r_cnt   <= 2'd0;
            end else if (w_eff_state == ST_HAZ) begin
                r_cnt   <= r_cnt - 2'd1;
                r_state <= (r_cnt == 2'd1) ? ST_RUN : ST_HAZ;
            end else if (bus.haz_req) begin
                r_cnt   <= w_haz_len - 2'd1;
                r_state <= (w_haz_len > 2'd1) ? ST_HAZ : ST_RUN;
            end else begin
                r_state <= ST_RUN;
            end
        end
    end
endmodule
